// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: splits an 8-lane vector load/store
// into single-word accesses on the single-port data SRAM.
module vec_mem_sequencer #(
    parameter int LANES  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    is_load_i,
    input  logic [LANES-1:0]        lane_mask_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [ADDR_W-1:0]       stride_i,
    input  logic [LANES*DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0]       sram_rdata_i,
    output logic                    sram_cen_n_o,
    output logic                    sram_wen_n_o,
    output logic [ADDR_W-1:0]       sram_addr_o,
    output logic [DATA_W-1:0]       sram_wdata_o,
    output logic [LANES*DATA_W-1:0] ld_data_o,
    output logic                    busy_o,
    output logic                    stall_o,
    output logic                    done_o
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_LOAD_WAIT,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [LANES-1:0]        pend_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       stride_q;
    logic [LANES*DATA_W-1:0] st_data_q;
    logic                    cap_vld_q;
    logic [LW-1:0]           cap_lane_q;
    logic [LW-1:0]           lane;
    logic [LANES-1:0]        lane_oh;
    logic [LANES-1:0]        pend_left;
    logic                    issue;
    logic                    accept;

    // Lowest-index pending lane is served first.
    always_comb begin
        lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend_q[i]) lane = LW'(i);
        end
        lane_oh   = LANES'(1) << lane;
        pend_left = pend_q & ~lane_oh;
        issue     = (state == S_STORE) || (state == S_LOAD);
        accept    = (state == S_IDLE) && start_i;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (lane_mask_i == '0) state_nx = S_DONE;
                    else if (is_load_i)    state_nx = S_LOAD;
                    else                   state_nx = S_STORE;
                end
            end
            S_STORE:     if (pend_left == '0) state_nx = S_DONE;
            S_LOAD:      if (pend_left == '0) state_nx = S_LOAD_WAIT;
            S_LOAD_WAIT: state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // SRAM strobes are masked by rst_n so an abort stops access at once.
    always_comb begin
        sram_cen_n_o = ~(issue && rst_n);
        sram_wen_n_o = ~((state == S_STORE) && rst_n);
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (issue) begin
            sram_addr_o = base_q + ADDR_W'(lane) * stride_q;
        end
        if (state == S_STORE) begin
            sram_wdata_o = st_data_q[lane*DATA_W +: DATA_W];
        end
        busy_o  = (state != S_IDLE);
        done_o  = (state == S_DONE);
        stall_o = busy_o || accept;
    end

    // Request capture, lane bookkeeping and load-data gather.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q     <= '0;
            base_q     <= '0;
            stride_q   <= '0;
            st_data_q  <= '0;
            cap_vld_q  <= 1'b0;
            cap_lane_q <= '0;
            ld_data_o  <= '0;
        end else begin
            if (accept) begin
                pend_q    <= lane_mask_i;
                base_q    <= base_addr_i;
                stride_q  <= stride_i;
                st_data_q <= st_data_i;
                if (is_load_i) ld_data_o <= '0;
            end else if (issue) begin
                pend_q <= pend_left;
            end
            cap_vld_q  <= (state == S_LOAD);
            cap_lane_q <= lane;
            if (cap_vld_q) begin
                ld_data_o[cap_lane_q*DATA_W +: DATA_W] <= sram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a
// behavioural single-port SRAM model (1-cycle read latency).
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic         is_load_i;
    logic [7:0]   lane_mask_i;
    logic [15:0]  base_addr_i;
    logic [15:0]  stride_i;
    logic [255:0] st_data_i;
    logic [31:0]  sram_rdata_i;
    logic         sram_cen_n_o;
    logic         sram_wen_n_o;
    logic [15:0]  sram_addr_o;
    logic [31:0]  sram_wdata_o;
    logic [255:0] ld_data_o;
    logic         busy_o;
    logic         stall_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;
    int dones;
    logic [255:0] exp_ld;
    logic [31:0]  mem [0:65535];

    vec_mem_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .is_load_i    (is_load_i),
        .lane_mask_i  (lane_mask_i),
        .base_addr_i  (base_addr_i),
        .stride_i     (stride_i),
        .st_data_i    (st_data_i),
        .sram_rdata_i (sram_rdata_i),
        .sram_cen_n_o (sram_cen_n_o),
        .sram_wen_n_o (sram_wen_n_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .ld_data_o    (ld_data_o),
        .busy_o       (busy_o),
        .stall_o      (stall_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // SRAM model: write on wen_n=0, registered read otherwise.
    always @(posedge clk) begin
        if (!sram_cen_n_o) begin
            if (!sram_wen_n_o) mem[sram_addr_o] <= sram_wdata_o;
            else               sram_rdata_i <= mem[sram_addr_o];
        end
    end

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ld, input logic [7:0] m,
                       input logic [15:0] b, input logic [15:0] s,
                       input logic [31:0] d0);
        start_i     = 1'b1;
        is_load_i   = ld;
        lane_mask_i = m;
        base_addr_i = b;
        stride_i    = s;
        for (int k = 0; k < 8; k++) st_data_i[k*32 +: 32] = d0 + k;
        #1;
    endtask

    task automatic acc(input string tag, input logic wen_n,
                       input logic [15:0] a, input logic [31:0] d);
        chk({tag, " cen_n"}, sram_cen_n_o, 1'b0);
        chk({tag, " wen_n"}, sram_wen_n_o, wen_n);
        chk({tag, " addr"}, sram_addr_o, a);
        if (!wen_n) chk({tag, " wdata"}, sram_wdata_o, d);
        chk({tag, " done"}, done_o, 1'b0);
        chk({tag, " stall"}, stall_o, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD_0000 | i;
        mem[16'h0010] = 32'h11;
        mem[16'h002C] = 32'h77;
        sram_rdata_i = '0;
        rst_n = 1'b0;
        start_i = 1'b0;
        is_load_i = 1'b0;
        lane_mask_i = '0;
        base_addr_i = '0;
        stride_i = '0;
        st_data_i = '0;
        tick();
        tick();
        chk("rst cen_n", sram_cen_n_o, 1'b1);
        chk("rst wen_n", sram_wen_n_o, 1'b1);
        chk("rst addr", sram_addr_o, 16'h0);
        chk("rst wdata", sram_wdata_o, 32'h0);
        chk("rst ld", ld_data_o, 256'h0);
        chk("rst busy", busy_o, 1'b0);
        chk("rst done", done_o, 1'b0);
        rst_n = 1'b1;
        tick();

        // Full 8-lane store, unit stride.
        req(1'b0, 8'hFF, 16'h0100, 16'h0001, 32'hA0);
        chk("st c0 stall", stall_o, 1'b1);
        chk("st c0 busy", busy_o, 1'b0);
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            acc($sformatf("st c%0d", c), 1'b0,
                16'h0100 + 16'(c - 1), 32'hA0 + 32'(c - 1));
            tick();
        end
        chk("st c9 done", done_o, 1'b1);
        chk("st c9 stall", stall_o, 1'b1);
        chk("st c9 cen_n", sram_cen_n_o, 1'b1);
        tick();
        chk("st c10 done", done_o, 1'b0);
        chk("st c10 busy", busy_o, 1'b0);
        chk("st c10 stall", stall_o, 1'b0);
        chk("st mem0", mem[16'h0100], 32'hA0);
        chk("st mem7", mem[16'h0107], 32'hA7);

        // Sparse load, lanes 0 and 7, stride 4.
        req(1'b1, 8'h81, 16'h0010, 16'h0004, 32'h0);
        tick();
        start_i = 1'b0;
        acc("ld c1", 1'b1, 16'h0010, 32'h0);
        chk("ld c1 ld", ld_data_o, 256'h0);
        tick();
        acc("ld c2", 1'b1, 16'h002C, 32'h0);
        tick();
        chk("ld c3 cen_n", sram_cen_n_o, 1'b1);
        chk("ld c3 done", done_o, 1'b0);
        tick();
        exp_ld = '0;
        exp_ld[31:0] = 32'h11;
        exp_ld[255:224] = 32'h77;
        chk("ld c4 done", done_o, 1'b1);
        chk("ld c4 data", ld_data_o, exp_ld);
        tick();
        chk("ld hold", ld_data_o, exp_ld);

        // Zero-mask load: no access, data cleared.
        req(1'b1, 8'h00, 16'h0040, 16'h0001, 32'h0);
        chk("zm c0 cen_n", sram_cen_n_o, 1'b1);
        tick();
        start_i = 1'b0;
        chk("zm c1 done", done_o, 1'b1);
        chk("zm c1 cen_n", sram_cen_n_o, 1'b1);
        chk("zm c1 ld", ld_data_o, 256'h0);
        tick();

        // Address wrap-around on a single lane.
        req(1'b0, 8'h04, 16'hFFFE, 16'h0002, 32'hC0);
        tick();
        start_i = 1'b0;
        acc("wr c1", 1'b0, 16'h0002, 32'hC2);
        tick();
        chk("wr c2 done", done_o, 1'b1);
        chk("wr c2 cen_n", sram_cen_n_o, 1'b1);
        tick();

        // Reset in cycle 3 of an 8-lane store.
        req(1'b0, 8'hFF, 16'h0200, 16'h0001, 32'hB0);
        tick();
        start_i = 1'b0;
        acc("ab c1", 1'b0, 16'h0200, 32'hB0);
        tick();
        acc("ab c2", 1'b0, 16'h0201, 32'hB1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("ab c4 cen_n", sram_cen_n_o, 1'b1);
        chk("ab c4 wen_n", sram_wen_n_o, 1'b1);
        chk("ab c4 busy", busy_o, 1'b0);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done_o) dones++;
            if (!sram_cen_n_o) dones++;
            tick();
        end
        chk("ab quiet", 32'(dones), 32'd0);
        chk("ab mem3", mem[16'h0203], 32'hDEAD_0203);
        req(1'b0, 8'h03, 16'h0300, 16'h0001, 32'hE0);
        tick();
        start_i = 1'b0;
        acc("ab2 c1", 1'b0, 16'h0300, 32'hE0);
        tick();
        acc("ab2 c2", 1'b0, 16'h0301, 32'hE1);
        tick();
        chk("ab2 c3 done", done_o, 1'b1);
        tick();

        // start_i held high through DONE.
        req(1'b0, 8'h01, 16'h0400, 16'h0001, 32'h50);
        tick();
        req(1'b0, 8'h02, 16'h0500, 16'h0010, 32'h60);
        acc("bb c1", 1'b0, 16'h0400, 32'h50);
        tick();
        chk("bb c2 done", done_o, 1'b1);
        chk("bb c2 cen_n", sram_cen_n_o, 1'b1);
        tick();
        chk("bb c3 busy", busy_o, 1'b0);
        chk("bb c3 stall", stall_o, 1'b1);
        tick();
        start_i = 1'b0;
        acc("bb c4", 1'b0, 16'h0510, 32'h61);
        tick();
        chk("bb c5 done", done_o, 1'b1);
        tick();
        chk("bb c6 busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
